// File: rtl/sys_defs.sv
// sys_defs: shared types and widths for the out-of-order core slice.
package sys_defs;
  localparam int XLEN = 32;
  localparam int ARCH_REGS = 32;
  localparam int AR_W = 5;
  localparam int PR_W = 6;
  localparam int CNT_W = 64;
  typedef struct packed {
    logic valid;
    logic [AR_W-1:0] arch_reg;
    logic [PR_W-1:0] Tnew;
    logic [PR_W-1:0] Told;
    logic is_store;
    logic precise_state_need;
    logic [XLEN-1:0] target_pc;
    logic halt;
  } ROB_ENTRY_PACKET;
  typedef enum logic [1:0] {RUN, RECOVER, HALT} retire_state_e;
endpackage

// File: rtl/retire_arbiter.sv
// retire_arbiter: picks committing slots (oldest first) and the single blocking slot, if any.
module retire_arbiter
  import sys_defs::*;
(
  input  ROB_ENTRY_PACKET [2:0] entries,
  output logic [2:0] commit,
  output logic recover,
  output logic [XLEN-1:0] recover_target,
  output logic halt
);
  logic blocked;
  always_comb begin
    commit = '0;
    recover = 1'b0;
    recover_target = '0;
    halt = 1'b0;
    blocked = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      commit[k] = entries[k].valid && !blocked;
      // a slot carrying both halt and mispredict halts; halt takes precedence
      if (commit[k] && entries[k].halt) halt = 1'b1;
      else if (commit[k] && entries[k].precise_state_need) begin
        recover = 1'b1;
        recover_target = entries[k].target_pc;
      end
      blocked = blocked || (commit[k] && (entries[k].halt || entries[k].precise_state_need));
    end
  end
endmodule

// File: rtl/retire_stage.sv
// retire_stage: in-order commit of up to 3 ROB entries; owns AMT, recovery and halt.
module retire_stage
  import sys_defs::*;
(
  input  logic clock,
  input  logic reset,
  input  ROB_ENTRY_PACKET [2:0] retire_entry,
  output logic BPRecoverEN,
  output logic [XLEN-1:0] recover_pc,
  output logic [ARCH_REGS-1:0][PR_W-1:0] arch_map,
  output logic [2:0] free_valid,
  output logic [2:0][PR_W-1:0] free_pr,
  output logic [2:0] store_retire,
  output logic halted,
  output logic [CNT_W-1:0] retire_count
);
  retire_state_e state, state_next;
  logic [2:0] commit, run_commit;
  logic rec, hlt;
  logic [XLEN-1:0] rec_target;
  logic [ARCH_REGS-1:0][PR_W-1:0] amt_next;
  retire_arbiter u_arb (
    .entries(retire_entry),
    .commit(commit),
    .recover(rec),
    .recover_target(rec_target),
    .halt(hlt)
  );
  assign run_commit = (state == RUN) ? commit : 3'b000;
  assign BPRecoverEN = state == RECOVER;
  assign halted = state == HALT;
  always_comb begin
    state_next = state;
    case (state)
      RUN: state_next = hlt ? HALT : rec ? RECOVER : RUN;
      RECOVER: state_next = RUN;
      default: state_next = HALT;
    endcase
  end
  // youngest slot is applied last so it wins on same-register writes
  always_comb begin
    amt_next = arch_map;
    for (int k = 2; k >= 0; k--)
      if (run_commit[k] && retire_entry[k].arch_reg != '0)
        amt_next[retire_entry[k].arch_reg] = retire_entry[k].Tnew;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      recover_pc <= '0;
      for (int i = 0; i < ARCH_REGS; i++) arch_map[i] <= PR_W'(i);
      free_valid <= '0;
      free_pr <= '0;
      store_retire <= '0;
      retire_count <= '0;
    end else begin
      state <= state_next;
      if (state == RUN && rec && !hlt) recover_pc <= rec_target;
      arch_map <= amt_next;
      for (int k = 0; k < 3; k++) begin
        free_valid[k] <= run_commit[k] && retire_entry[k].arch_reg != '0;
        free_pr[k] <= (run_commit[k] && retire_entry[k].arch_reg != '0) ? retire_entry[k].Told : '0;
        store_retire[k] <= run_commit[k] && retire_entry[k].is_store;
      end
      retire_count <= retire_count + CNT_W'($countones(run_commit));
    end
  end
endmodule
